// File: rtl/ncpu32k_wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results onto the register file write port.
// Optional macro NCPU_WB_BYPASS_EN lets an LSU result skip an empty FIFO (1-cycle latency).
module ncpu32k_wb_arbiter #(
  parameter int REG_AW     = 5,
  parameter int DW         = 32,
  parameter int FIFO_AW    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd_addr,
  input  logic [DW-1:0]     alu_dout,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd_addr,
  input  logic [DW-1:0]     lsu_dout,
  input  logic              wb_flush,
  output logic              regf_we,
  output logic [REG_AW-1:0] regf_din_addr,
  output logic [DW-1:0]     regf_din,
  output logic              wb_pending
);

  localparam int                 DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [3:0]         STARVE_LIM = 4'(STARVE_MAX);

  logic [REG_AW-1:0]  fifo_addr [DEPTH];
  logic [DW-1:0]      fifo_data [DEPTH];
  logic [FIFO_AW-1:0] rptr, wptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic [3:0]         cnt, cnt_nxt;

  logic empty, full;
  logic alu_wr, lsu_wr, pop, push, bypass;

  assign empty      = (count == '0);
  assign full       = (count == COUNT_FULL);
  assign lsu_ready  = !full;
  assign alu_ready  = (cnt != STARVE_LIM);
  assign wb_pending = !empty;

  // r0 results are accepted but never reach the port or the FIFO.
  assign alu_wr = alu_valid && alu_ready && (alu_rd_addr != '0);
  assign lsu_wr = lsu_valid && lsu_ready && (lsu_rd_addr != '0);
  assign pop    = !alu_wr && !empty;

`ifdef NCPU_WB_BYPASS_EN
  assign bypass = !alu_wr && empty && lsu_wr;
`else
  assign bypass = 1'b0;
`endif

  assign push = lsu_wr && !bypass && !wb_flush;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    count_nxt = count;
    if (wb_flush) begin
      count_nxt = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_nxt = count + COUNT_ONE;
        2'b01:   count_nxt = count - COUNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // A pop or an empty FIFO means nothing is starving; saturate otherwise.
  always_comb begin
    cnt_nxt = cnt;
    if (wb_flush || empty || pop) cnt_nxt = '0;
    else if (cnt != STARVE_LIM)   cnt_nxt = cnt + 4'd1;
  end

  // NOTE: FIFO storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= lsu_rd_addr;
      fifo_data[wptr] <= lsu_dout;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      cnt   <= '0;
    end else begin
      count <= count_nxt;
      cnt   <= cnt_nxt;
      if (wb_flush) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_ONE;
        if (pop)  rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Address/data hold their last value when no source is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regf_we       <= 1'b0;
      regf_din_addr <= '0;
      regf_din      <= '0;
    end else if (alu_wr) begin
      regf_we       <= 1'b1;
      regf_din_addr <= alu_rd_addr;
      regf_din      <= alu_dout;
    end else if (pop) begin
      regf_we       <= 1'b1;
      regf_din_addr <= fifo_addr[rptr];
      regf_din      <= fifo_data[rptr];
    end else if (bypass) begin
      regf_we       <= 1'b1;
      regf_din_addr <= lsu_rd_addr;
      regf_din      <= lsu_dout;
    end else begin
      regf_we       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ncpu32k_wb_arbiter.sv
// Self-checking bench for ncpu32k_wb_arbiter: vector table, corner sequences, random traffic vs. a queue model.
module tb_ncpu32k_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;
`ifdef NCPU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_dout;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_dout;
  logic        wb_flush;
  logic        regf_we;
  logic [4:0]  regf_din_addr;
  logic [31:0] regf_din;
  logic        wb_pending;

  always #5 clk = ~clk;

  ncpu32k_wb_arbiter #(.REG_AW(5), .DW(32), .FIFO_AW(1), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_addr(alu_rd_addr), .alu_dout(alu_dout),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr), .lsu_dout(lsu_dout),
    .wb_flush(wb_flush),
    .regf_we(regf_we), .regf_din_addr(regf_din_addr), .regf_din(regf_din),
    .wb_pending(wb_pending)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered results as a queue, starvation as a plain integer.
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  int          m_cnt;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_we = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                            input bit lv, input logic [4:0] lrd, input logic [31:0] ld, input bit fl);
    bit   was_ne, alu_w, lsu_w, popped, byp;
    ent_t e;
    was_ne = (q.size() != 0);
    alu_w  = av && (m_cnt != SMAX) && (ard != 0);
    lsu_w  = lv && (q.size() < DEPTH) && (lrd != 0);
    popped = 0; byp = 0;
    if (alu_w) begin
      m_we = 1; m_addr = ard; m_data = ad;
    end else if (was_ne) begin
      e = q.pop_front();
      m_we = 1; m_addr = e.a; m_data = e.d; popped = 1;
    end else if (BYP && lsu_w) begin
      m_we = 1; m_addr = lrd; m_data = ld; byp = 1;
    end else begin
      m_we = 0;
    end
    if (fl) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (lsu_w && !byp) q.push_back('{a: lrd, d: ld});
      if (was_ne && !popped) m_cnt = (m_cnt < SMAX) ? m_cnt + 1 : SMAX;
      else                   m_cnt = 0;
    end
  endtask

  task automatic check_state();
    check("alu_ready",  32'(alu_ready),  32'(m_cnt != SMAX));
    check("lsu_ready",  32'(lsu_ready),  32'(q.size() < DEPTH));
    check("wb_pending", 32'(wb_pending), 32'(q.size() != 0));
    check("regf_we",    32'(regf_we),    32'(m_we));
    if (m_we) begin
      check("regf_din_addr", 32'(regf_din_addr), 32'(m_addr));
      check("regf_din",      regf_din,            m_data);
    end
  endtask

  // Checks current outputs, drives one cycle of inputs, advances to 1 time unit past the next edge.
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld, input bit fl);
    check_state();
    alu_valid = av; alu_rd_addr = ard; alu_dout = ad;
    lsu_valid = lv; lsu_rd_addr = lrd; lsu_dout = ld;
    wb_flush  = fl;
    model_step(av, ard, ad, lv, lrd, ld, fl);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  typedef struct {
    bit av; logic [4:0] ard; logic [31:0] ad;
    bit lv; logic [4:0] lrd; logic [31:0] ld;
    bit we; logic [4:0] addr; logic [31:0] data; bit pend;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [4:0]  lsu_a [3];
    logic [31:0] lsu_d [3];

    rst_n = 1'b0;
    alu_valid = 0; alu_rd_addr = '0; alu_dout = '0;
    lsu_valid = 0; lsu_rd_addr = '0; lsu_dout = '0;
    wb_flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_regf_we",   32'(regf_we),       32'd0);
    check("reset_addr",      32'(regf_din_addr), 32'd0);
    check("reset_din",       regf_din,           32'd0);
    check("reset_alu_ready", 32'(alu_ready),     32'd1);
    check("reset_lsu_ready", 32'(lsu_ready),     32'd1);
    check("reset_pending",   32'(wb_pending),    32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: inputs for one cycle, expected outputs after the following edge.
    tbl.push_back('{1, 5'd3, 32'h11, 0, 5'd0, 32'h0,    1, 5'd3, 32'h11,   0});
    tbl.push_back('{1, 5'd4, 32'h22, 0, 5'd0, 32'h0,    1, 5'd4, 32'h22,   0});
    tbl.push_back('{1, 5'd0, 32'h33, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0});
`ifdef NCPU_WB_BYPASS_EN
    tbl.push_back('{0, 5'd0, 32'h0,  1, 5'd7, 32'hDEAD, 1, 5'd7, 32'hDEAD, 0});
    tbl.push_back('{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0});
    tbl.push_back('{1, 5'd0, 32'h44, 1, 5'd6, 32'hBEEF, 1, 5'd6, 32'hBEEF, 0});
    tbl.push_back('{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0});
`else
    tbl.push_back('{0, 5'd0, 32'h0,  1, 5'd7, 32'hDEAD, 0, 5'd0, 32'h0,    1});
    tbl.push_back('{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    1, 5'd7, 32'hDEAD, 0});
    tbl.push_back('{1, 5'd0, 32'h44, 1, 5'd6, 32'hBEEF, 0, 5'd0, 32'h0,    1});
    tbl.push_back('{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    1, 5'd6, 32'hBEEF, 0});
`endif
    tbl.push_back('{0, 5'd0, 32'h0,  1, 5'd0, 32'h55,   0, 5'd0, 32'h0,    0});
    tbl.push_back('{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0});
    foreach (tbl[i]) begin
      cycle(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld, 0);
      check($sformatf("vec%0d_we", i),   32'(regf_we),    32'(tbl[i].we));
      check($sformatf("vec%0d_pend", i), 32'(wb_pending), 32'(tbl[i].pend));
      if (tbl[i].we) begin
        check($sformatf("vec%0d_addr", i), 32'(regf_din_addr), 32'(tbl[i].addr));
        check($sformatf("vec%0d_data", i), regf_din,            tbl[i].data);
      end
    end

    // Starvation: one buffered entry behind a continuously writing ALU.
    cycle(1, 5'd1, 32'h100, 1, 5'd5, 32'hAA, 0);
    for (int k = 1; k <= SMAX; k++) begin
      check($sformatf("starve_ready_c%0d", k), 32'(alu_ready), 32'd1);
      cycle(1, 5'd2, 32'h200 + 32'(k), 0, 5'd0, 32'd0, 0);
    end
    check("starve_ready_low", 32'(alu_ready), 32'd0);
    cycle(1, 5'd2, 32'h2FF, 0, 5'd0, 32'd0, 0);
    check("starve_we",       32'(regf_we),       32'd1);
    check("starve_addr",     32'(regf_din_addr), 32'd5);
    check("starve_data",     regf_din,           32'hAA);
    check("starve_ready_up", 32'(alu_ready),     32'd1);
    idle(3);

    // Fill to full: three LSU results offered back-to-back under ALU pressure.
    lsu_a = '{5'd12, 5'd13, 5'd14};
    lsu_d = '{32'hC0, 32'hC1, 32'hC2};
    idx = 0;
    for (int c = 0; c < 30 && idx < 3; c++) begin
      if (c == 2) check("fill_ready_low", 32'(lsu_ready), 32'd0);
      if (lsu_ready) begin
        cycle(1, 5'd8, 32'h800 + 32'(c), 1, lsu_a[idx], lsu_d[idx], 0);
        idx++;
      end else begin
        cycle(1, 5'd8, 32'h800 + 32'(c), 1, lsu_a[idx], lsu_d[idx], 0);
      end
    end
    check("fill_all_accepted", 32'(idx), 32'd3);
    idle(4);
    check("fill_drained", 32'(wb_pending), 32'd0);

    // Flush: two buffered entries plus an offered third, all discarded.
    cycle(1, 5'd1, 32'h1, 1, 5'd9,  32'h90, 0);
    cycle(1, 5'd1, 32'h2, 1, 5'd10, 32'hA0, 0);
    check("flush_pre_pending", 32'(wb_pending), 32'd1);
    cycle(1, 5'd1, 32'h3, 1, 5'd11, 32'hB0, 1);
    check("flush_pending", 32'(wb_pending), 32'd0);
    for (int c = 0; c < 8; c++) begin
      check("flush_no_write",
            32'(regf_we && (regf_din_addr >= 5'd9) && (regf_din_addr <= 5'd11)), 32'd0);
      cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    end

    // Async reset in mid-cycle with a full FIFO and an active write.
    cycle(1, 5'd1, 32'h11, 1, 5'd20, 32'h20, 0);
    cycle(1, 5'd1, 32'h12, 1, 5'd21, 32'h21, 0);
    check("rst_pre_we",   32'(regf_we),   32'd1);
    check("rst_pre_full", 32'(lsu_ready), 32'd0);
    alu_valid = 0; lsu_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we",        32'(regf_we),       32'd0);
    check("async_rst_addr",      32'(regf_din_addr), 32'd0);
    check("async_rst_din",       regf_din,           32'd0);
    check("async_rst_alu_ready", 32'(alu_ready),     32'd1);
    check("async_rst_lsu_ready", 32'(lsu_ready),     32'd1);
    check("async_rst_pending",   32'(wb_pending),    32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom(),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 6)), $urandom(),
            $urandom_range(0, 19) == 0);
    end
    idle(SMAX + 3);
    check_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ncpu32k_wb_arbiter.md
# ncpu32k_wb_arbiter

Write-back arbiter: the writer side of the register file. It merges results from the single-cycle ALU path and the multi-cycle LSU/MUL path onto the register file's single write port (`regf_din_addr` / `regf_din` / `regf_we`). LSU results are buffered in a small FIFO, and a starvation counter guarantees that buffered results drain. It sits between the execute units and the register file write port; register outputs are driven from flops.

## Interface
Parameters:
- `REG_AW`, 5 — register address width.
- `DW`, 32 — data width.
- `FIFO_AW`, 1 — log2 of LSU FIFO depth; default depth is 2.
- `STARVE_MAX`, 4 — consecutive non-draining cycles before the ALU is stalled. Legal range is 1..15.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — one clock; reset is asynchronous and active-low.
- `alu_valid` in 1 — ALU result valid.
- `alu_ready` out 1 — ALU result accepted when `alu_valid & alu_ready`.
- `alu_rd_addr` in `REG_AW` — ALU destination register.
- `alu_dout` in `DW` — ALU result.
- `lsu_valid` in 1 — LSU/MUL result valid.
- `lsu_ready` out 1 — LSU result accepted when `lsu_valid & lsu_ready`.
- `lsu_rd_addr` in `REG_AW` — LSU destination register.
- `lsu_dout` in `DW` — LSU result.
- `wb_flush` in 1 — discard all buffered LSU results.
- `regf_we` out 1 — register file write enable (registered).
- `regf_din_addr` out `REG_AW` — write address (registered).
- `regf_din` out `DW` — write data (registered).
- `wb_pending` out 1 — FIFO non-empty.

## Operation
- **Reset values:** `regf_we`=0, `regf_din_addr`=0, `regf_din`=0, FIFO empty, starvation counter 0, `alu_ready`=1, `lsu_ready`=1, `wb_pending`=0.
- **r0 filtering:**
  - An accepted ALU result with rd=0 produces no write and does not occupy the port that cycle.
  - An accepted LSU result with rd=0 is not pushed into the FIFO.
- **Per-cycle port selection, in priority order:**
  1. An accepted ALU result with rd≠0.
  2. Otherwise the FIFO head, if non-empty; this pops the head.
  3. Otherwise the bypassed LSU input (only when `NCPU_WB_BYPASS_EN` is defined).
  4. Otherwise no write.
- **Output register:** the selected result is loaded into the output register at the next edge. `regf_we`=1 only when a source was selected.
- **FIFO push:** an accepted LSU result with rd≠0 that is not bypassed is pushed.
- **`lsu_ready`:** equals `!full`, computed from the current count. When full there is no push even if a pop occurs the same cycle.
- **Starvation counter `cnt`:**
  - Increments, saturating at `STARVE_MAX`, on each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop, and whenever the FIFO is empty.
- **`alu_ready`:** `alu_ready` = (`cnt` != `STARVE_MAX`). In the cycle `alu_ready` is 0 the head is guaranteed to pop, so `cnt` returns to 0.
- **Flush:** `wb_flush` empties the FIFO and clears `cnt` at the next edge.
  - An LSU push in the flush cycle is discarded.
  - A pop selected in the flush cycle still writes.
  - The output register and the ALU path are unaffected.
- **Ordering:** WAW ordering between the ALU and LSU paths to the same rd is the issue stage's responsibility. The arbiter preserves FIFO order only.

## Timing
- **ALU:** accepted at cycle N → `regf_we` at N+1. Throughput is 1 per cycle.
- **LSU, FIFO path:** accepted at N → earliest `regf_we` at N+2.
- **LSU, bypass path:** accepted at N with FIFO empty and no ALU write → `regf_we` at N+1.
- **Worst-case LSU drain:** a non-empty FIFO head writes within `STARVE_MAX`+1 cycles.
- **Simultaneous push and pop, FIFO non-full:** count is unchanged and pointers wrap modulo depth.
- **`wb_pending`:** reflects the registered count; no lookahead.
- **Reset asserted mid-operation:** all state clears immediately and buffered results are lost.

## Configuration
- **`NCPU_WB_BYPASS_EN` defined:** when the FIFO is empty and no ALU write is selected, an accepted LSU result goes directly to the output register (1-cycle latency) and is not pushed.
- **`NCPU_WB_BYPASS_EN` undefined:** every LSU result with rd≠0 passes through the FIFO (minimum 2-cycle latency).
- Port list and all other behaviour are identical in both builds.

## Test plan
- **ALU only:** `alu_valid`=1 for 3 cycles with rd=3,4,0 and data 0x11,0x22,0x33 → writes (3,0x11) and (4,0x22) on consecutive cycles; the rd=0 cycle gives `regf_we`=0.
- **LSU while ALU idle:** single LSU rd=7, data 0xDEAD at cycle N → `regf_we` at N+1 with `NCPU_WB_BYPASS_EN`, at N+2 without it.
- **Fill to full:** ALU continuously valid and 3 LSU results offered back-to-back → `lsu_ready` drops after 2 pushes; third result held until a pop.
- **Starvation (`STARVE_MAX`=4):** FIFO holding rd=5, data 0xAA, ALU valid every cycle → `alu_ready`=0 exactly in the 5th cycle after push, (5,0xAA) written next edge, `alu_ready` returns to 1.
- **Flush:** FIFO holding 2 entries plus an LSU push in the same cycle as `wb_flush` → `wb_pending`=0 after the edge; none of the three entries are ever written.
- **Async reset mid-stream:** `rst_n` low while FIFO is full and `regf_we`=1 → all outputs reach reset values without waiting for `clk`.
